// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-issue RV32I instruction fetch unit
// Owns the PC, fetches over a req/ack handshake and applies the Address Builder's redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    output logic [31:0] pc,
    input  logic        ab_valid,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] pc_AB,
    output logic        fetch_misaligned,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        ERR
    } state_t;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_ARB  = 2'b10;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    state_t      state_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic        instr_valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_addr_q;
    logic [31:0] pc_q;
    logic        fetch_misaligned_q;
    logic [31:0] instret_q;

    logic [31:0] next_addr_d;
    logic [31:0] seq_pc_d;
    logic        redirect_bad_d;

    // pc_sel = 11 is treated like PC_4 so a reserved code can never stall the core.
    always_comb begin
        next_addr_d    = (pc_sel == PC_ARB) ? pc_AB : pc_q;
        redirect_bad_d = (pc_sel == PC_ARB) && (pc_AB[1:0] != 2'b00);
        seq_pc_d       = imem_addr_q + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            imem_req_q         <= 1'b0;
            imem_addr_q        <= RESET_PC;
            instr_valid_q      <= 1'b0;
            instr_q            <= NOP;
            instr_addr_q       <= 32'h0;
            pc_q               <= 32'h0;
            fetch_misaligned_q <= 1'b0;
            instret_q          <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= FETCH;
                    imem_req_q  <= 1'b1;
                    imem_addr_q <= RESET_PC;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state_q       <= ISSUE;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        instr_q       <= imem_rdata;
                        instr_addr_q  <= imem_addr_q;
                        pc_q          <= seq_pc_d;
                    end
                end
                ISSUE: begin
                    if (ab_valid && (pc_sel != PC_HOLD)) begin
                        instret_q     <= instret_q + 32'd1;
                        instr_valid_q <= 1'b0;
                        if (redirect_bad_d) begin
                            state_q            <= ERR;
                            fetch_misaligned_q <= 1'b1;
                        end else begin
                            state_q     <= FETCH;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= next_addr_d;
                        end
                    end
                end
                default: begin
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req         = imem_req_q;
    assign imem_addr        = imem_addr_q;
    assign instr_valid      = instr_valid_q;
    assign instr            = instr_q;
    assign instr_addr       = instr_addr_q;
    assign pc               = pc_q;
    assign fetch_misaligned = fetch_misaligned_q;
    assign instret          = instret_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Single-issue instruction fetch unit for the RV32I core. It owns the program counter, fetches one instruction at a time from instruction memory over a req/ack handshake, and holds the instruction for decode and address building. It then applies the Address Builder's `pc_sel`/`pc_AB` decision to select the next fetch address. It is the stage directly upstream of the Address Builder, and it consumes that block's outputs.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: address of the first fetch after reset; must be word aligned.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  memory returns `imem_rdata` in this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr` and the PCs below are valid.
- `instr`  out  32  held instruction, fed to decode, which produces `opcode`, `funct3` and `imm_ext`.
- `instr_addr`  out  32  address of the held instruction.
- `pc`  out  32  `instr_addr + 4`; this is the value fed to the Address Builder `pc` input.
- `ab_valid`  in  1  `pc_sel`/`pc_AB` are resolved for the held instruction.
- `pc_sel`  in  2  00 = PC (hold), 01 = PC_4, 10 = PC_ARB, 11 = reserved.
- `pc_AB`  in  32  redirect target when `pc_sel` = PC_ARB.
- `fetch_misaligned`  out  1  sticky error flag for a misaligned redirect target.
- `instret`  out  32  count of retired instructions.

## Operation
The FSM has four states: IDLE, FETCH, ISSUE and ERR.

- IDLE: this is the reset state. It moves to FETCH on the first edge after `rst` is released, with `imem_addr` = `RESET_PC`.
- FETCH:
  - `imem_req` is high.
  - On `imem_ack`, the block latches `instr` = `imem_rdata` and `instr_addr` = `imem_addr`, sets `pc` = `imem_addr + 4`, and moves to ISSUE.
- ISSUE:
  - `instr_valid` is high, and `instr`, `instr_addr` and `pc` are frozen.
  - The block waits for `ab_valid`, then acts on `pc_sel`:
    - 01 or 11: the next fetch address is `pc`; move to FETCH.
    - 10: the next fetch address is `pc_AB`.
      - If `pc_AB[1:0]` = 00, move to FETCH.
      - Otherwise set `fetch_misaligned` and move to ERR without issuing the fetch.
    - 00: stay in ISSUE with the same instruction still presented; re-sample `ab_valid` on the next cycle.
  - `instret` increments by 1 (mod 2^32) on every `ab_valid` taken with `pc_sel` ≠ 00.
- ERR: `imem_req` = 0 and `instr_valid` = 0. Only `rst` exits this state.
- Arithmetic: all address arithmetic is 32-bit with wrap-around, so 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.

## Timing
All outputs are registered. Reset values:
- `imem_req` = 0, `imem_addr` = `RESET_PC`
- `instr_valid` = 0, `instr` = 32'h0000_0013 (NOP)
- `instr_addr` = 0, `pc` = 0
- `fetch_misaligned` = 0, `instret` = 0

Cycle-level behaviour:
- After `rst` is released, `imem_req` rises on the 1st rising edge.
- If `imem_ack` is sampled in cycle N, `instr_valid` is high in cycle N+1 and `imem_req` is low in N+1.
  - Minimum fetch loop: 1 cycle in FETCH with a same-cycle ack, plus 1 cycle in ISSUE.
- If `ab_valid` is sampled in cycle M, then in cycle M+1 `instr_valid` = 0, `imem_req` = 1 and `imem_addr` = the next address.
- `imem_ack` while `imem_req` = 0 is ignored.
- `ab_valid` outside ISSUE is ignored.
- Memory may hold `imem_ack` low for an unbounded number of cycles; `imem_req`/`imem_addr` stay stable throughout.
- `rst` asserted mid-fetch or mid-issue immediately clears all outputs to their reset values. A late `imem_ack` arriving after reset release is ignored until FETCH is re-entered.
- `pc_sel` and `pc_AB` are sampled only in the `ab_valid` cycle; values on them at other times have no effect.

## Test plan
- Reset and sequential fetch:
  - Stimulus: `RESET_PC` = 32'h100, ack with 0-cycle latency, `ab_valid` with `pc_sel` = 01 each ISSUE.
  - Required: `imem_addr` sequence 100, 104, 108; `pc` = 104 on the first issue; `instret` = 3 after 3 ab_valids.
- Jump redirect:
  - Stimulus: in ISSUE at 32'h200, `ab_valid` with `pc_sel` = 10 and `pc_AB` = 32'h40.
  - Required: next cycle `imem_req` = 1 with `imem_addr` = 32'h40; `instr_valid` = 0.
- Hold:
  - Stimulus: `ab_valid` with `pc_sel` = 00 for 3 cycles, then 01.
  - Required: `instr`/`pc` unchanged and no `imem_req` during the hold; `instret` increments only once.
- Slow memory:
  - Stimulus: `imem_ack` delayed 5 cycles.
  - Required: `imem_req`/`imem_addr` stable for 6 cycles; `instr_valid` rises 1 cycle after the ack.
- Misaligned target:
  - Stimulus: `pc_sel` = 10 with `pc_AB` = 32'h0000_0102.
  - Required: `fetch_misaligned` = 1 next cycle; `imem_req` stays 0 until `rst`.
- Async reset mid-fetch:
  - Stimulus: assert `rst` while `imem_req` = 1 at 32'h300, between edges.
  - Required: `imem_req` = 0 and `imem_addr` = `RESET_PC` without waiting for an edge; after release, fetch restarts at `RESET_PC`.
